// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single-ported physical memory.
// Ties alternate between ports; one transaction is in flight at a time.
module mem_arbiter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_read,
  input  logic [WIDTH-1:0] i_address,
  output logic [WIDTH-1:0] i_rdata,
  output logic             i_resp,
  input  logic             d_read,
  input  logic             d_write,
  input  logic [WIDTH-1:0] d_address,
  input  logic [WIDTH-1:0] d_wdata,
  input  logic [1:0]       d_byte_enable,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic [WIDTH-1:0] pmem_address,
  output logic [WIDTH-1:0] pmem_wdata,
  output logic [1:0]       pmem_byte_enable,
  input  logic [WIDTH-1:0] pmem_rdata,
  input  logic             pmem_resp
);

  typedef enum logic [2:0] {IDLE, I_BUSY, D_BUSY, I_DONE, D_DONE} state_t;

  state_t           state_q, state_d;
  logic             last_d_q, last_d_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]       be_q, be_d;
  logic             write_q, write_d;
  logic [WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic             d_req;

  assign d_req = d_read | d_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      write_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      write_q   <= write_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    write_d   = write_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        // D wins when it is alone or when I held the previous grant
        if (d_req && (!i_read || !last_d_q)) begin
          state_d  = D_BUSY;
          last_d_d = 1'b1;
          addr_d   = d_address;
          wdata_d  = d_wdata;
          be_d     = d_byte_enable;
          write_d  = d_write;
        end else if (i_read) begin
          state_d  = I_BUSY;
          last_d_d = 1'b0;
          addr_d   = i_address;
          be_d     = 2'b11;
          write_d  = 1'b0;
        end
      end
      I_BUSY: begin
        if (pmem_resp) begin
          i_rdata_d = pmem_rdata;
          state_d   = I_DONE;
        end
      end
      D_BUSY: begin
        if (pmem_resp) begin
          if (!write_q) d_rdata_d = pmem_rdata;
          state_d = D_DONE;
        end
      end
      I_DONE:  state_d = IDLE;
      D_DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_address     = '0;
    pmem_wdata       = '0;
    pmem_byte_enable = '0;
    i_resp           = 1'b0;
    d_resp           = 1'b0;
    unique case (state_q)
      I_BUSY, D_BUSY: begin
        pmem_read        = ~write_q;
        pmem_write       = write_q;
        pmem_address     = addr_q;
        pmem_wdata       = wdata_q;
        pmem_byte_enable = be_q;
      end
      I_DONE:  i_resp = 1'b1;
      D_DONE:  d_resp = 1'b1;
      default: ;
    endcase
  end

  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change and outputs are sampled on the falling edge.
module tb_mem_arbiter;
  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_read;
  logic [WIDTH-1:0] i_address;
  logic [WIDTH-1:0] i_rdata;
  logic             i_resp;
  logic             d_read;
  logic             d_write;
  logic [WIDTH-1:0] d_address;
  logic [WIDTH-1:0] d_wdata;
  logic [1:0]       d_byte_enable;
  logic [WIDTH-1:0] d_rdata;
  logic             d_resp;
  logic             pmem_read;
  logic             pmem_write;
  logic [WIDTH-1:0] pmem_address;
  logic [WIDTH-1:0] pmem_wdata;
  logic [1:0]       pmem_byte_enable;
  logic [WIDTH-1:0] pmem_rdata;
  logic             pmem_resp;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.WIDTH(WIDTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_read           (i_read),
    .i_address        (i_address),
    .i_rdata          (i_rdata),
    .i_resp           (i_resp),
    .d_read           (d_read),
    .d_write          (d_write),
    .d_address        (d_address),
    .d_wdata          (d_wdata),
    .d_byte_enable    (d_byte_enable),
    .d_rdata          (d_rdata),
    .d_resp           (d_resp),
    .pmem_read        (pmem_read),
    .pmem_write       (pmem_write),
    .pmem_address     (pmem_address),
    .pmem_wdata       (pmem_wdata),
    .pmem_byte_enable (pmem_byte_enable),
    .pmem_rdata       (pmem_rdata),
    .pmem_resp        (pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0; d_byte_enable = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;

    #3;
    chk("rst_pmem_read",  16'(pmem_read),  16'h0);
    chk("rst_pmem_write", 16'(pmem_write), 16'h0);
    chk("rst_pmem_addr",  pmem_address,    16'h0);
    chk("rst_i_resp",     16'(i_resp),     16'h0);
    chk("rst_d_resp",     16'(d_resp),     16'h0);
    chk("rst_i_rdata",    i_rdata,         16'h0);
    chk("rst_d_rdata",    d_rdata,         16'h0);

    // Single instruction fetch, memory answers two cycles after the grant
    @(negedge clk);
    rst = 1'b0; i_read = 1'b1; i_address = 16'h0010;
    @(negedge clk);
    chk("t1_pmem_read_c1", 16'(pmem_read), 16'h1);
    chk("t1_addr_c1",      pmem_address,   16'h0010);
    chk("t1_pmem_write",   16'(pmem_write), 16'h0);
    chk("t1_no_resp_busy", 16'(i_resp),    16'h0);
    i_read = 1'b0;
    @(negedge clk);
    chk("t1_pmem_read_c2", 16'(pmem_read), 16'h1);
    chk("t1_addr_c2",      pmem_address,   16'h0010);
    pmem_resp = 1'b1; pmem_rdata = 16'h1234;
    @(negedge clk);
    pmem_resp = 1'b0;
    chk("t1_i_resp",       16'(i_resp),    16'h1);
    chk("t1_d_resp",       16'(d_resp),    16'h0);
    chk("t1_pmem_read_dn", 16'(pmem_read), 16'h0);
    chk("t1_i_rdata",      i_rdata,        16'h1234);
    @(negedge clk);
    chk("t1_i_resp_drop",  16'(i_resp),    16'h0);
    chk("t1_i_rdata_hold", i_rdata,        16'h1234);

    // Reset pulse between edges, then simultaneous requests: D first
    rst = 1'b1;
    #1;
    chk("t2_rst_i_rdata", i_rdata, 16'h0);
    #1;
    rst = 1'b0;
    i_read = 1'b1; i_address = 16'h0020;
    d_read = 1'b1; d_address = 16'h0040;
    @(negedge clk);
    chk("t2_d_first_addr", pmem_address,   16'h0040);
    chk("t2_d_first_read", 16'(pmem_read), 16'h1);
    pmem_resp = 1'b1; pmem_rdata = 16'hA5A5;
    @(negedge clk);
    pmem_resp = 1'b0;
    chk("t2_d_resp",   16'(d_resp), 16'h1);
    chk("t2_i_resp0",  16'(i_resp), 16'h0);
    chk("t2_d_rdata",  d_rdata,     16'hA5A5);
    d_read = 1'b0;
    @(negedge clk);
    chk("t2_idle_read", 16'(pmem_read), 16'h0);
    @(negedge clk);
    chk("t2_i_second_addr", pmem_address,   16'h0020);
    chk("t2_i_second_read", 16'(pmem_read), 16'h1);
    pmem_resp = 1'b1; pmem_rdata = 16'h5A5A;
    @(negedge clk);
    pmem_resp = 1'b0;
    chk("t2_i_resp",  16'(i_resp), 16'h1);
    chk("t2_i_rdata", i_rdata,     16'h5A5A);
    d_read = 1'b1;
    @(negedge clk);
    // Both pending with I last granted: D wins
    @(negedge clk);
    chk("t2_tie2_addr", pmem_address, 16'h0040);
    pmem_resp = 1'b1; pmem_rdata = 16'h1111;
    @(negedge clk);
    pmem_resp = 1'b0;
    chk("t2_tie2_d_resp", 16'(d_resp), 16'h1);
    chk("t2_tie2_rdata",  d_rdata,     16'h1111);
    @(negedge clk);
    chk("t2_idle_resp_i", 16'(i_resp),    16'h0);
    chk("t2_idle_resp_d", 16'(d_resp),    16'h0);
    chk("t2_idle_rd",     16'(pmem_read), 16'h0);
    // Both pending with D last granted: I wins
    @(negedge clk);
    chk("t2_tie3_addr", pmem_address, 16'h0020);
    i_read = 1'b0; d_read = 1'b0;
    pmem_resp = 1'b1; pmem_rdata = 16'h2222;
    @(negedge clk);
    pmem_resp = 1'b0;
    chk("t2_tie3_i_resp",  16'(i_resp), 16'h1);
    chk("t2_tie3_i_rdata", i_rdata,     16'h2222);
    chk("t2_d_rdata_hold", d_rdata,     16'h1111);
    @(negedge clk);

    // Byte write; request-side inputs disturbed while busy
    d_write = 1'b1; d_address = 16'h0200; d_wdata = 16'hBEEF; d_byte_enable = 2'b01;
    @(negedge clk);
    chk("t3_pmem_write", 16'(pmem_write), 16'h1);
    chk("t3_pmem_read",  16'(pmem_read),  16'h0);
    chk("t3_addr",       pmem_address,    16'h0200);
    chk("t3_wdata",      pmem_wdata,      16'hBEEF);
    chk("t3_be",         16'(pmem_byte_enable), 16'h1);
    d_address = 16'h0300; d_wdata = 16'h0000; d_byte_enable = 2'b10; d_write = 1'b0;
    @(negedge clk);
    chk("t3_addr_held",  pmem_address,    16'h0200);
    chk("t3_wdata_held", pmem_wdata,      16'hBEEF);
    chk("t3_be_held",    16'(pmem_byte_enable), 16'h1);
    chk("t3_write_held", 16'(pmem_write), 16'h1);
    pmem_resp = 1'b1; pmem_rdata = 16'hDEAD;
    @(negedge clk);
    pmem_resp = 1'b0;
    chk("t3_d_resp",       16'(d_resp),     16'h1);
    chk("t3_d_rdata_keep", d_rdata,         16'h1111);
    chk("t3_write_drop",   16'(pmem_write), 16'h0);
    @(negedge clk);

    // Stray memory response while idle is ignored
    pmem_resp = 1'b1; pmem_rdata = 16'h7777;
    @(negedge clk);
    pmem_resp = 1'b0;
    chk("t4_stray_i_resp", 16'(i_resp), 16'h0);
    chk("t4_stray_d_resp", 16'(d_resp), 16'h0);
    chk("t4_stray_i_rd",   i_rdata,     16'h2222);
    chk("t4_stray_d_rd",   d_rdata,     16'h1111);

    // Read and write both asserted: performed as a write
    d_read = 1'b1; d_write = 1'b1; d_address = 16'h0300; d_wdata = 16'hCAFE; d_byte_enable = 2'b11;
    @(negedge clk);
    chk("t5_write", 16'(pmem_write), 16'h1);
    chk("t5_read",  16'(pmem_read),  16'h0);
    chk("t5_wdata", pmem_wdata,      16'hCAFE);
    d_read = 1'b0; d_write = 1'b0;
    pmem_resp = 1'b1; pmem_rdata = 16'h3333;
    @(negedge clk);
    pmem_resp = 1'b0;
    chk("t5_d_resp", 16'(d_resp),    16'h1);
    chk("t5_read_dn", 16'(pmem_read), 16'h0);
    @(negedge clk);

    // Reset in the middle of a fetch, request still held afterwards
    i_read = 1'b1; i_address = 16'h0050;
    @(negedge clk);
    chk("t6_busy_read", 16'(pmem_read), 16'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_read", 16'(pmem_read), 16'h0);
    chk("t6_rst_addr", pmem_address,   16'h0);
    chk("t6_rst_resp", 16'(i_resp),    16'h0);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_regrant_read", 16'(pmem_read), 16'h1);
    chk("t6_regrant_addr", pmem_address,   16'h0050);
    chk("t6_no_resp",      16'(i_resp),    16'h0);
    pmem_resp = 1'b1; pmem_rdata = 16'h4444;
    @(negedge clk);
    pmem_resp = 1'b0;
    i_read = 1'b0;
    chk("t6_i_resp",  16'(i_resp), 16'h1);
    chk("t6_i_rdata", i_rdata,     16'h4444);
    @(negedge clk);
    chk("t6_i_resp_drop", 16'(i_resp), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, data and address width in bits (lc3b_word).
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 i_read  in  1  instruction-port read request; i_address  in  WIDTH  fetch address.
REQ-005 i_rdata  out  WIDTH  fetched word; i_resp  out  1  one-cycle completion pulse.
REQ-006 d_read, d_write  in  1 each  data-port requests; d_address, d_wdata  in  WIDTH; d_byte_enable  in  2.
REQ-007 d_rdata  out  WIDTH  loaded word; d_resp  out  1  one-cycle completion pulse.
REQ-008 pmem_read, pmem_write  out  1 each; pmem_address, pmem_wdata  out  WIDTH; pmem_byte_enable  out  2.
REQ-009 pmem_rdata  in  WIDTH; pmem_resp  in  1  physical-memory completion, single-cycle.

Function
REQ-010 FSM states: IDLE, I_BUSY, D_BUSY, I_DONE, D_DONE.
REQ-011 IDLE, no request pending: stay IDLE, all pmem_* outputs 0.
REQ-012 IDLE, only i_read: latch i_address, go I_BUSY.
REQ-013 IDLE, only d_read or d_write: latch d_address, d_wdata, d_byte_enable, op type; go D_BUSY.
REQ-014 IDLE, both ports pending: grant the port not granted last (last_grant register); last_grant updates on every grant.
REQ-015 d_read and d_write both high: treated as a write; d_rdata undefined for that transaction.
REQ-016 I_BUSY/D_BUSY: drive pmem_* from latched values only; held stable until pmem_resp.
REQ-017 Request-side inputs changing or dropping during BUSY: no effect; transaction completes.
REQ-018 BUSY with pmem_resp=1: capture pmem_rdata into port's rdata register, go to matching DONE state.
REQ-019 pmem_read/pmem_write deassert in the cycle after pmem_resp (DONE state).
REQ-020 I_DONE: i_resp=1 for exactly one cycle; D_DONE: d_resp=1 for exactly one cycle; next state IDLE.
REQ-021 Never both i_resp and d_resp in same cycle; never both pmem_read and pmem_write.
REQ-022 Requester still asserting in IDLE after its resp = new request; arbitrated normally.
REQ-023 Minimum latency request-to-resp: 3 cycles with pmem_resp in first BUSY cycle (IDLE grant, BUSY, DONE).
REQ-024 i_rdata/d_rdata hold last captured value until next capture for that port.
REQ-025 pmem_resp in IDLE or DONE: ignored.
REQ-026 Write transactions: d_rdata not updated; d_resp still pulsed.

Reset
REQ-027 rst=1: state IDLE, last_grant=I (D wins first tie), all pmem_*, i_resp, d_resp, i_rdata, d_rdata = 0, immediately (asynchronous).
REQ-028 rst mid-transaction: transaction abandoned, no resp pulsed, pmem_* drop to 0 without waiting for clock.
REQ-029 After rst deasserts, first arbitration on next rising edge.

Verification
REQ-030 i_read, i_address=0x0010, pmem_resp 2 cycles after grant with rdata=0x1234 -> pmem_read/address 0x0010 held; i_resp pulse one cycle, i_rdata=0x1234.
REQ-031 i_read and d_read same cycle after reset -> D granted first, then I; second i_read/d_read tie -> D again only if I was last granted.
REQ-032 d_write, d_address=0x0200, d_wdata=0xBEEF, byte_enable=2'b01 -> pmem_write, matching address/data/byte_enable stable until pmem_resp; d_resp pulse; d_rdata unchanged.
REQ-033 d_address changed to 0x0300 during D_BUSY -> pmem_address remains 0x0200.
REQ-034 rst asserted during I_BUSY -> pmem_read 0 immediately, no i_resp; after release, pending i_read re-granted.
REQ-035 d_read and d_write both high -> write performed, pmem_read never asserted.
